// File: rtl/set_count_gen.sv
// Lattice set counter: scans a GRID x GRID point grid against NUM_SET circles and counts points meeting a mode.
// Optional macro SET_MASK_EN adds a per-circle enable mask latched with each job.
module set_count_gen #(
  parameter  int NUM_SET = 3,
  parameter  int GRID    = 8,
  parameter  int CW      = 4,
  localparam int CNT_W   = $clog2(GRID*GRID+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [2*CW*NUM_SET-1:0]   central,
  input  logic [CW*NUM_SET-1:0]     radius,
  input  logic [1:0]                mode,
`ifdef SET_MASK_EN
  input  logic [NUM_SET-1:0]        set_mask,
`endif
  output logic                      busy,
  output logic                      valid,
  output logic [CNT_W-1:0]          candidate
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             x_q, x_d, y_q, y_d;
  logic [2*CW*NUM_SET-1:0]   central_q, central_d;
  logic [CW*NUM_SET-1:0]     radius_q, radius_d;
  logic [1:0]                mode_q, mode_d;
  logic [NUM_SET-1:0]        mask_eff;
  logic [NUM_SET-1:0]        in_p0;
  logic [NUM_SET-1:0]        in_p1_q, in_p1_d;
  logic                      vld_p1_q, vld_p1_d;
  logic [CNT_W-1:0]          acc_q, acc_d;
  logic                      accept;
  logic                      hit_p1;
  int                        cnt_p1;

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Squares are widened before multiplying so off-grid centres never wrap.
  function automatic logic in_circle(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                     input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                     input logic [CW-1:0] r);
    logic [2*CW-1:0] dx, dy, rr;
    logic [2*CW:0]   d2;
    dx = {{CW{1'b0}}, abs_diff(px, cx)};
    dy = {{CW{1'b0}}, abs_diff(py, cy)};
    rr = {{CW{1'b0}}, r};
    d2 = {1'b0, dx * dx} + {1'b0, dy * dy};
    return d2 <= {1'b0, rr * rr};
  endfunction

  function automatic int popcount(input logic [NUM_SET-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_SET; i++) n += 32'(v[i]);
    return n;
  endfunction

`ifdef SET_MASK_EN
  logic [NUM_SET-1:0] mask_q, mask_d;
  always_comb begin
    mask_d = mask_q;
    if (accept) mask_d = set_mask;
  end
  always_ff @(posedge clk) mask_q <= mask_d;
  assign mask_eff = mask_q;
`else
  assign mask_eff = '1;
`endif

  assign accept = en && ((state_q == IDLE) || (state_q == DONE));
  assign busy   = (state_q == SCAN) || (state_q == DRAIN);
  assign valid  = (state_q == DONE);
  assign candidate = acc_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    if (accept) begin
      central_d = central;
      radius_d  = radius;
      mode_d    = mode;
    end
    case (state_q)
      IDLE:  if (en) state_d = SCAN;
      SCAN: begin
        if (x_q == CW'(GRID)) begin
          x_d = CW'(1);
          if (y_q == CW'(GRID)) begin
            y_d     = CW'(1);
            state_d = DRAIN;
          end else begin
            y_d = y_q + CW'(1);
          end
        end else begin
          x_d = x_q + CW'(1);
        end
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = en ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: membership flags of the issued point.
  always_comb begin
    for (int i = 0; i < NUM_SET; i++) begin
      in_p0[i] = in_circle(x_q, y_q,
                           central_q[(NUM_SET-i)*2*CW-1 -: CW],
                           central_q[(NUM_SET-i)*2*CW-CW-1 -: CW],
                           radius_q[(NUM_SET-i)*CW-1 -: CW]) & mask_eff[i];
    end
    in_p1_d  = in_p0;
    vld_p1_d = (state_q == SCAN);
  end

  // Stage p1 -> accumulator: mode predicate on the registered flags.
  always_comb begin
    cnt_p1 = popcount(in_p1_q);
    case (mode_q)
      2'b00:   hit_p1 = in_p1_q[0];
      2'b01:   hit_p1 = (mask_eff != '0) && (cnt_p1 == popcount(mask_eff));
      2'b10:   hit_p1 = (cnt_p1 == 1);
      default: hit_p1 = (cnt_p1 == 2);
    endcase
    acc_d = acc_q;
    if (accept)                  acc_d = '0;
    else if (vld_p1_q && hit_p1) acc_d = acc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= CW'(1);
      y_q      <= CW'(1);
      vld_p1_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vld_p1_q <= vld_p1_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    central_q <= central_d;
    radius_q  <= radius_d;
    mode_q    <= mode_d;
    in_p1_q   <= in_p1_d;
  end

endmodule

// File: tb/tb_set_count_gen.sv
// Bench for set_count_gen at default parameters: table vectors, hand sequences and random jobs vs. a lattice model.
module tb_set_count_gen;

  localparam int NS = 3;
  localparam int G  = 8;
  localparam int CW = 4;
  localparam int CNT_W = $clog2(G*G+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2*CW*NS-1:0] central;
  logic [CW*NS-1:0] radius;
  logic [1:0]       mode;
  logic [NS-1:0]    set_mask;
  logic             busy, valid;
  logic [CNT_W-1:0] candidate;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  set_count_gen dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius), .mode(mode),
`ifdef SET_MASK_EN
    .set_mask(set_mask),
`endif
    .busy(busy), .valid(valid), .candidate(candidate)
  );

  typedef struct {
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    int          exp;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [23:0] cen(input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2);
    return {4'(x0), 4'(y0), 4'(x1), 4'(y1), 4'(x2), 4'(y2)};
  endfunction

  function automatic logic [11:0] rad(input int r0, input int r1, input int r2);
    return {4'(r0), 4'(r1), 4'(r2)};
  endfunction

  // Reference: walk the lattice and count by the membership rules directly.
  function automatic int model(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                               input logic [NS-1:0] mk);
    int total, k, nen, cx, cy, rr;
    bit in0;
    bit ins [NS];
    total = 0;
    nen = 0;
    for (int i = 0; i < NS; i++) nen += int'(mk[i]);
    for (int y = 1; y <= G; y++) begin
      for (int x = 1; x <= G; x++) begin
        k = 0;
        for (int i = 0; i < NS; i++) begin
          cx = int'(c[(NS-i)*8-1 -: 4]);
          cy = int'(c[(NS-i)*8-5 -: 4]);
          rr = int'(r[(NS-i)*4-1 -: 4]);
          ins[i] = mk[i] && ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rr*rr);
          if (ins[i]) k++;
        end
        in0 = ins[0];
        case (m)
          2'b00: if (in0) total++;
          2'b01: if (nen > 0 && k == nen) total++;
          2'b10: if (k == 1) total++;
          default: if (k == 2) total++;
        endcase
      end
    end
    return total;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one job; optionally scramble inputs and pulse en while busy.
  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input logic [NS-1:0] mk, input bit noisy, output int cand);
    int n;
    bit seen;
    central = c; radius = r; mode = m; set_mask = mk; en = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", int'(busy), 1);
    en = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (noisy && n < 60) begin
        en = 1'($urandom);
        central = 24'($urandom);
        radius = 12'($urandom);
        mode = 2'($urandom);
        set_mask = NS'($urandom);
      end else begin
        en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (valid) seen = 1'b1;
    end
    check("valid_latency", n, 65);
    check("busy_low_in_done", int'(busy), 0);
    cand = int'(candidate);
    @(posedge clk); #1;
    check("valid_one_cycle", int'(valid), 0);
    check("candidate_hold", int'(candidate), cand);
  endtask

  initial begin
    int cand, cand2, n, exp;
    bit any;
    logic [23:0] rc;
    logic [11:0] rr;
    logic [1:0]  rm;
    logic [NS-1:0] rk;

    tbl[0] = '{cen(4,4,1,1,8,8), rad(2,0,0), 2'b00, 13};
    tbl[1] = '{cen(4,4,1,1,8,8), rad(2,0,0), 2'b10, 15};
    tbl[2] = '{cen(4,4,4,4,1,1), rad(2,2,0), 2'b11, 13};
    tbl[3] = '{cen(1,1,0,0,0,0), rad(3,0,0), 2'b00, 11};
    tbl[4] = '{cen(4,4,0,0,0,0), rad(15,0,0), 2'b00, 64};
    tbl[5] = '{cen(4,4,4,4,4,4), rad(2,2,2), 2'b01, 13};
    tbl[6] = '{cen(4,4,4,4,4,4), rad(2,2,2), 2'b10, 0};
    tbl[7] = '{cen(0,0,15,15,4,4), rad(1,15,2), 2'b00, 0};

    rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0; set_mask = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_candidate", int'(candidate), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].c, tbl[i].r, tbl[i].m, '1, (i % 2) == 1, cand);
      check($sformatf("table_%0d", i), cand, tbl[i].exp);
    end

    // Back-to-back: en held high through DONE.
    central = tbl[0].c; radius = tbl[0].r; mode = tbl[0].m; set_mask = '1; en = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", n, 65);
    check("b2b_first_cand", int'(candidate), 13);
    check("b2b_busy_done", int'(busy), 0);
    central = tbl[1].c; radius = tbl[1].r; mode = tbl[1].m;
    @(posedge clk); #1;
    en = 1'b0;
    check("b2b_restart_busy", int'(busy), 1);
    check("b2b_restart_valid", int'(valid), 0);
    n = 1;
    while (!valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_valid_spacing", n, 66);
    check("b2b_second_cand", int'(candidate), 15);
    @(posedge clk); #1;

    // Reset in the middle of a scan aborts the job.
    central = tbl[5].c; radius = tbl[5].r; mode = tbl[5].m; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_candidate", int'(candidate), 0);
    any = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (valid || busy) any = 1'b1;
    end
    check("abort_stays_idle", int'(any), 0);
    run_job(tbl[3].c, tbl[3].r, tbl[3].m, '1, 1'b0, cand);
    check("after_abort_cand", cand, 11);

    // Random jobs against the lattice model.
    for (int j = 0; j < 12; j++) begin
      rc = 24'($urandom);
      rr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      rm = 2'($urandom);
`ifdef SET_MASK_EN
      rk = NS'($urandom);
`else
      rk = '1;
`endif
      exp = model(rc, rr, rm, rk);
      run_job(rc, rr, rm, rk, j[0], cand2);
      check($sformatf("random_%0d", j), cand2, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
